cpu_memory_responder: RTL and testbench

- Target-side bus interface for the CPU core. Consumes the CPU's external address bus (ABH/ABL), data-out (DOR) byte and read/write strobe, and returns the read byte that feeds the CPU's external data-bus read input.
- Bridges each CPU access onto an external memory port with an ack handshake. Stalls the CPU with cpu_ready until the access completes.
- Drops writes to a write-protected ROM window.
- Aborts hung accesses after a timeout, returning an open-bus value and setting a sticky error flag.

---
 rtl/cpu_memory_responder_if.sv | 73 +++++++
 rtl/cpu_memory_responder.sv | 154 +++++++++++++++
 tb/tb_cpu_memory_responder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_memory_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_memory_responder_if
// Description : Groups the CPU-side request/response signals and the external
//               memory-port handshake used by cpu_memory_responder.
//               'slave' is the responder's view; 'master' is the view of the
//               agent that drives the CPU requests and answers the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_memory_responder_if;

  // CPU side
  logic [7:0]  cpu_addr_low;
  logic [7:0]  cpu_addr_high;
  logic [7:0]  cpu_data_write;
  logic        cpu_rw;
  logic        cpu_valid;
  logic [7:0]  cpu_data_read;
  logic        cpu_ready;
  logic        access_done;

  // External memory port
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_cyc;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  // Error reporting
  logic        bus_error;
  logic        err_clear;

  modport slave (
    input  cpu_addr_low,
    input  cpu_addr_high,
    input  cpu_data_write,
    input  cpu_rw,
    input  cpu_valid,
    output cpu_data_read,
    output cpu_ready,
    output access_done,
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_cyc,
    input  mem_ack,
    input  mem_rdata,
    output bus_error,
    input  err_clear
  );

  modport master (
    output cpu_addr_low,
    output cpu_addr_high,
    output cpu_data_write,
    output cpu_rw,
    output cpu_valid,
    input  cpu_data_read,
    input  cpu_ready,
    input  access_done,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_cyc,
    output mem_ack,
    output mem_rdata,
    input  bus_error,
    output err_clear
  );

endinterface
`default_nettype wire

// File: rtl/cpu_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_memory_responder
// Description : Bridges each CPU access onto an external memory port with an
//               ack handshake, stalling the CPU via cpu_ready until the access
//               completes. Writes into the ROM window are dropped locally.
//               Accesses that never see an ack are aborted after WAIT_TIMEOUT
//               cycles, returning OPEN_BUS_VALUE on reads and raising a sticky
//               bus_error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_memory_responder #(
  parameter int unsigned WAIT_TIMEOUT   = 15,     // legal range 1..255
  parameter logic [7:0]  OPEN_BUS_VALUE = 8'hFF,
  parameter logic [7:0]  ROM_BASE_HIGH  = 8'hF0
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_memory_responder_if.slave bus
);

  // Last value the wait timer reaches before the cycle is aborted.
  localparam logic [7:0] c_timer_last = 8'(WAIT_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t       state_q,         state_d;
  logic [7:0]   timer_q,         timer_d;
  logic         cpu_ready_q,     cpu_ready_d;
  logic [7:0]   cpu_data_read_q, cpu_data_read_d;
  logic         access_done_q,   access_done_d;
  logic [15:0]  mem_addr_q,      mem_addr_d;
  logic [7:0]   mem_wdata_q,     mem_wdata_d;
  logic         mem_we_q,        mem_we_d;
  logic         mem_cyc_q,       mem_cyc_d;
  logic         bus_error_q,     bus_error_d;

  // A write whose high address byte falls in the ROM window never reaches
  // the memory port; it is acknowledged locally on the next cycle.
  logic w_protected_write;
  assign w_protected_write = !bus.cpu_rw && (bus.cpu_addr_high >= ROM_BASE_HIGH);

  // The external cycle ends on ack, or on the last permitted wait cycle.
  logic w_timeout;
  assign w_timeout = !bus.mem_ack && (timer_q == c_timer_last);

  // Next-state and output computation for the IDLE/BUS controller.
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    cpu_ready_d     = cpu_ready_q;
    cpu_data_read_d = cpu_data_read_q;
    access_done_d   = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_we_d        = mem_we_q;
    mem_cyc_d       = mem_cyc_q;
    bus_error_d     = bus_error_q;

    // Clear is evaluated first so that a timeout on the same edge overrides it.
    if (bus.err_clear) begin
      bus_error_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_valid) begin
          if (w_protected_write) begin
            access_done_d = 1'b1;
          end else begin
            mem_addr_d  = {bus.cpu_addr_high, bus.cpu_addr_low};
            mem_wdata_d = bus.cpu_data_write;
            mem_we_d    = !bus.cpu_rw;
            mem_cyc_d   = 1'b1;
            cpu_ready_d = 1'b0;
            timer_d     = 8'd0;
            state_d     = ST_BUS;
          end
        end
      end

      ST_BUS: begin
        if (bus.mem_ack || w_timeout) begin
          // mem_we_q still describes the access in flight; writes never
          // touch the read-data register, even when aborted.
          if (!mem_we_q) begin
            cpu_data_read_d = bus.mem_ack ? bus.mem_rdata : OPEN_BUS_VALUE;
          end
          if (w_timeout) begin
            bus_error_d = 1'b1;
          end
          mem_cyc_d     = 1'b0;
          mem_we_d      = 1'b0;
          cpu_ready_d   = 1'b1;
          access_done_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register update; reset abandons any in-flight access without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      timer_q         <= 8'd0;
      cpu_ready_q     <= 1'b1;
      cpu_data_read_q <= 8'h00;
      access_done_q   <= 1'b0;
      mem_addr_q      <= 16'h0000;
      mem_wdata_q     <= 8'h00;
      mem_we_q        <= 1'b0;
      mem_cyc_q       <= 1'b0;
      bus_error_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      cpu_ready_q     <= cpu_ready_d;
      cpu_data_read_q <= cpu_data_read_d;
      access_done_q   <= access_done_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_we_q        <= mem_we_d;
      mem_cyc_q       <= mem_cyc_d;
      bus_error_q     <= bus_error_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output drive (all outputs come straight from registers)
  // --------------------------------------------------------------------------
  assign bus.cpu_ready     = cpu_ready_q;
  assign bus.cpu_data_read = cpu_data_read_q;
  assign bus.access_done   = access_done_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_cyc       = mem_cyc_q;
  assign bus.bus_error     = bus_error_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_memory_responder
// Description : Self-checking bench for cpu_memory_responder. Directed steps
//               for the listed scenarios followed by randomized accesses, all
//               checked against a transaction-level expectation model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_memory_responder;

  localparam int unsigned WAIT_TIMEOUT   = 15;
  localparam logic [7:0]  OPEN_BUS_VALUE = 8'hFF;
  localparam logic [7:0]  ROM_BASE_HIGH  = 8'hF0;

  logic clk;
  logic rst;

  cpu_memory_responder_if dif();

  cpu_memory_responder #(
    .WAIT_TIMEOUT   (WAIT_TIMEOUT),
    .OPEN_BUS_VALUE (OPEN_BUS_VALUE),
    .ROM_BASE_HIGH  (ROM_BASE_HIGH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Expectation model: architecturally visible state after each transaction.
  logic [7:0]  exp_rd;
  logic        exp_err;
  logic [15:0] exp_addr;
  logic [7:0]  exp_wdata;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle, optionally pulsing err_clear.
  task automatic idle_cycle(input bit clr);
    dif.cpu_valid = 1'b0;
    dif.err_clear = clr;
    tick();
    dif.err_clear = 1'b0;
    if (clr) exp_err = 1'b0;
    chk("idle_done",  {15'd0, dif.access_done}, 16'd0);
    chk("idle_cyc",   {15'd0, dif.mem_cyc},     16'd0);
    chk("idle_ready", {15'd0, dif.cpu_ready},   16'd1);
    chk("idle_err",   {15'd0, dif.bus_error},   {15'd0, exp_err});
    chk("idle_rd",    {8'd0, dif.cpu_data_read}, {8'd0, exp_rd});
  endtask

  // One CPU access. ack_at = BUS cycle (1-based) in which mem_ack is given;
  // 0 or anything beyond WAIT_TIMEOUT means the memory never answers.
  // clr_last drives err_clear in the final BUS cycle.
  task automatic do_access(input bit rw, input logic [15:0] addr, input logic [7:0] wd,
                           input int ack_at, input logic [7:0] rd, input bit clr_last);
    bit prot;
    bit acked;
    bit done;
    int n;
    prot = !rw && (addr[15:8] >= ROM_BASE_HIGH);
    chk("ready_before", {15'd0, dif.cpu_ready}, 16'd1);
    dif.cpu_valid      = 1'b1;
    dif.cpu_rw         = rw;
    dif.cpu_addr_high  = addr[15:8];
    dif.cpu_addr_low   = addr[7:0];
    dif.cpu_data_write = wd;
    dif.mem_ack        = 1'b0;
    tick();
    dif.cpu_valid = 1'b0;
    if (prot) begin
      chk("prot_cyc",   {15'd0, dif.mem_cyc},     16'd0);
      chk("prot_ready", {15'd0, dif.cpu_ready},   16'd1);
      chk("prot_done",  {15'd0, dif.access_done}, 16'd1);
      chk("prot_addr",  dif.mem_addr,             exp_addr);
      chk("prot_wdata", {8'd0, dif.mem_wdata},    {8'd0, exp_wdata});
      chk("prot_rd",    {8'd0, dif.cpu_data_read}, {8'd0, exp_rd});
      return;
    end
    exp_addr  = addr;
    exp_wdata = wd;
    chk("start_cyc",   {15'd0, dif.mem_cyc},     16'd1);
    chk("start_ready", {15'd0, dif.cpu_ready},   16'd0);
    chk("start_done",  {15'd0, dif.access_done}, 16'd0);
    chk("start_addr",  dif.mem_addr,             exp_addr);
    chk("start_we",    {15'd0, dif.mem_we},      {15'd0, ~rw});
    chk("start_wdata", {8'd0, dif.mem_wdata},    {8'd0, exp_wdata});
    n    = 0;
    done = 1'b0;
    while (!done) begin
      n++;
      acked = (n == ack_at);
      // Noise on the CPU side must be ignored while the cycle is in flight.
      dif.cpu_valid     = 1'($urandom_range(0, 1));
      dif.cpu_rw        = 1'($urandom_range(0, 1));
      dif.cpu_addr_high = 8'($urandom);
      dif.cpu_addr_low  = 8'($urandom);
      dif.cpu_data_write = 8'($urandom);
      dif.mem_ack       = acked;
      dif.mem_rdata     = acked ? rd : 8'($urandom);
      dif.err_clear     = clr_last && (acked || n == int'(WAIT_TIMEOUT));
      tick();
      dif.mem_ack   = 1'b0;
      dif.err_clear = 1'b0;
      dif.cpu_valid = 1'b0;
      if (acked || n == int'(WAIT_TIMEOUT)) begin
        done = 1'b1;
        if (acked) begin
          if (rw) exp_rd = rd;
          if (clr_last) exp_err = 1'b0;
        end else begin
          if (rw) exp_rd = OPEN_BUS_VALUE;
          exp_err = 1'b1;
        end
        chk("end_cyc",   {15'd0, dif.mem_cyc},      16'd0);
        chk("end_we",    {15'd0, dif.mem_we},       16'd0);
        chk("end_ready", {15'd0, dif.cpu_ready},    16'd1);
        chk("end_done",  {15'd0, dif.access_done},  16'd1);
        chk("end_rd",    {8'd0, dif.cpu_data_read}, {8'd0, exp_rd});
        chk("end_err",   {15'd0, dif.bus_error},    {15'd0, exp_err});
      end else begin
        chk("wait_cyc",   {15'd0, dif.mem_cyc},     16'd1);
        chk("wait_ready", {15'd0, dif.cpu_ready},   16'd0);
        chk("wait_done",  {15'd0, dif.access_done}, 16'd0);
        chk("wait_addr",  dif.mem_addr,             exp_addr);
        chk("wait_we",    {15'd0, dif.mem_we},      {15'd0, ~rw});
        chk("wait_wdata", {8'd0, dif.mem_wdata},    {8'd0, exp_wdata});
      end
    end
  endtask

  // Hard stop in case the run gets stuck.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_rd      = 8'h00;
    exp_err     = 1'b0;
    exp_addr    = 16'h0000;
    exp_wdata   = 8'h00;

    rst                = 1'b1;
    dif.cpu_addr_low   = 8'h55;
    dif.cpu_addr_high  = 8'h11;
    dif.cpu_data_write = 8'hAA;
    dif.cpu_rw         = 1'b0;
    dif.cpu_valid      = 1'b1;
    dif.mem_ack        = 1'b1;
    dif.mem_rdata      = 8'h3E;
    dif.err_clear      = 1'b0;

    // Reset values
    repeat (2) tick();
    chk("rst_ready", {15'd0, dif.cpu_ready},     16'd1);
    chk("rst_rd",    {8'd0, dif.cpu_data_read},  16'd0);
    chk("rst_done",  {15'd0, dif.access_done},   16'd0);
    chk("rst_cyc",   {15'd0, dif.mem_cyc},       16'd0);
    chk("rst_we",    {15'd0, dif.mem_we},        16'd0);
    chk("rst_addr",  dif.mem_addr,               16'h0000);
    chk("rst_wdata", {8'd0, dif.mem_wdata},      16'd0);
    chk("rst_err",   {15'd0, dif.bus_error},     16'd0);
    rst           = 1'b0;
    dif.cpu_valid = 1'b0;

    // Stray ack while idle is ignored
    dif.mem_ack   = 1'b1;
    dif.mem_rdata = 8'h99;
    tick();
    dif.mem_ack = 1'b0;
    chk("stray_cyc",  {15'd0, dif.mem_cyc},      16'd0);
    chk("stray_done", {15'd0, dif.access_done},  16'd0);
    chk("stray_rd",   {8'd0, dif.cpu_data_read}, 16'd0);

    // Read acked on first BUS cycle
    do_access(1'b1, 16'h1234, 8'h00, 1, 8'hA5, 1'b0);
    idle_cycle(1'b0);

    // Write with three wait cycles
    do_access(1'b0, 16'h0200, 8'h3C, 4, 8'h00, 1'b0);
    idle_cycle(1'b0);

    // Protected write, then the same data just below the ROM window
    do_access(1'b0, 16'hF0FF, 8'h77, 1, 8'h00, 1'b0);
    idle_cycle(1'b0);
    do_access(1'b0, 16'hEFFF, 8'h77, 2, 8'h00, 1'b0);

    // Timeout read (back-to-back with the previous completion)
    do_access(1'b1, 16'h4000, 8'h00, 0, 8'h00, 1'b0);
    // Successful read keeps the sticky flag; then clear it
    do_access(1'b1, 16'h4001, 8'h00, 1, 8'h6B, 1'b0);
    idle_cycle(1'b1);

    // Ack in the final permitted cycle wins
    do_access(1'b1, 16'h5555, 8'h00, int'(WAIT_TIMEOUT), 8'h5A, 1'b0);

    // Timeout write with err_clear on the same edge: set wins, read data kept
    do_access(1'b0, 16'h0777, 8'hC3, 0, 8'h00, 1'b1);
    idle_cycle(1'b0);

    // Reset during the second BUS cycle of a write
    dif.cpu_valid      = 1'b1;
    dif.cpu_rw         = 1'b0;
    dif.cpu_addr_high  = 8'h03;
    dif.cpu_addr_low   = 8'h00;
    dif.cpu_data_write = 8'h5E;
    tick();
    dif.cpu_valid = 1'b0;
    chk("mid_cyc1", {15'd0, dif.mem_cyc}, 16'd1);
    tick();
    chk("mid_cyc2", {15'd0, dif.mem_cyc}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rd    = 8'h00;
    exp_err   = 1'b0;
    exp_addr  = 16'h0000;
    exp_wdata = 8'h00;
    chk("mid_cyc",   {15'd0, dif.mem_cyc},     16'd0);
    chk("mid_ready", {15'd0, dif.cpu_ready},   16'd1);
    chk("mid_addr",  dif.mem_addr,             16'h0000);
    chk("mid_done",  {15'd0, dif.access_done}, 16'd0);
    chk("mid_err",   {15'd0, dif.bus_error},   16'd0);
    idle_cycle(1'b0);
    do_access(1'b1, 16'h0ABC, 8'h00, 2, 8'h42, 1'b0);

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      bit          r_rw;
      logic [15:0] r_addr;
      int          r_ack;
      r_rw          = 1'($urandom_range(0, 1));
      r_addr[15:8]  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255))
                                                  : 8'($urandom_range(0, 255));
      r_addr[7:0]   = 8'($urandom);
      r_ack         = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, WAIT_TIMEOUT));
      do_access(r_rw, r_addr, 8'($urandom), r_ack, 8'($urandom),
                $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1) idle_cycle($urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
